// File: rtl/gpu_pkg.sv
// gpu_pkg
// Definitions shared by the GPU opcode front end: the shape encoding carried in
// the top nibble of every opcode, and the default widths of the colour and
// coordinate fields. Both the existing opcode decoder and the queued decoder
// import this package so that they agree on what a legal opcode is.
package gpu_pkg;

  // Shape codes. Every 4-bit value outside this list is an illegal opcode.
  typedef enum logic [3:0] {
    LINE     = 4'b0000,
    TRIANGLE = 4'b0001,
    CIRCLE   = 4'b0010
  } shape_t;

  localparam int DEF_COORD_W = 19;
  localparam int DEF_COLOR_W = 16;

  // True when the raw shape nibble names one of the shapes the pipeline can draw.
  function automatic logic isLegalShape(input logic [3:0] shapeBits);
    logic legal;
    legal = 1'b0;
    case (shapeBits)
      LINE, TRIANGLE, CIRCLE: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with power-of-two depth. Pointers are exactly log2(DEPTH)
// bits wide so they wrap on their own; a separate occupancy counter tells a full
// queue apart from an empty one.
//
// Ports
//   clk, rst      clock and asynchronous active-high reset (clears pointers and count)
//   push          write wdata at the tail; ignored while full
//   pop           advance the head; ignored while empty
//   flush         clear pointers and count; wins over push and pop that cycle
//   wdata         entry to store
//   rdata         entry at the head (combinational read, undefined while empty)
//   full, empty   occupancy flags
//   count         number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic w_doPush;
  logic w_doPop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rdPtr];

  // Protect the pointers against a caller that pushes when full or pops when
  // empty; flush cancels both operations for the cycle.
  assign w_doPush = push && !full  && !flush;
  assign w_doPop  = pop  && !empty && !flush;

  // Storage carries no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= wdata;
    end
  end

  // Pointers and occupancy. A simultaneous push and pop moves both pointers and
  // leaves the count where it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/opcode_queue_decoder.sv
// opcode_queue_decoder
// Accepts raw GPU opcodes, throws away those whose shape is not drawable, and
// queues the rest so a downstream rasteriser can take them at its own pace. The
// head entry is split into shape, colour and coordinate fields.
//
// Ports
//   clk, rst             clock and asynchronous active-high reset
//   flush                synchronous clear of the queue (drop counter untouched)
//   in_valid, in_ready   input handshake; in_ready is low only while the queue is full
//   opcode               {shape[3:0], colour, four coordinates}
//   out_valid, out_ready output handshake for the queue head
//   shape, color, opdata fields of the head entry
//   count                queue occupancy
//   illegal              one-cycle pulse after an illegal opcode was swallowed
//   drop_cnt             saturating count of swallowed opcodes
module opcode_queue_decoder
  import gpu_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int DEPTH   = 4,
  localparam int OP_W   = 4 + COLOR_W + 4 * COORD_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           shape,
  output logic [COLOR_W-1:0]   color,
  output logic [4*COORD_W-1:0] opdata,
  output logic [CNT_W-1:0]     count,
  output logic                 illegal,
  output logic [7:0]           drop_cnt
);

  logic            w_full;
  logic            w_empty;
  logic            w_xfer;
  logic            w_legal;
  logic            w_push;
  logic            w_pop;
  logic [OP_W-1:0] w_head;
  logic            r_illegal;
  logic [7:0]      r_dropCnt;

  // in_ready looks only at registered occupancy, so a pop in the same cycle
  // never opens a slot for a push when the queue is full.
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;

  assign w_xfer  = in_valid && in_ready;
  assign w_legal = isLegalShape(opcode[OP_W-1 -: 4]);
  assign w_push  = w_xfer && w_legal;
  assign w_pop   = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (OP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (flush),
    .wdata (opcode),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  // The stored word is the opcode untouched, so the fields are plain slices.
  assign shape  = w_head[OP_W-1 -: 4];
  assign color  = w_head[OP_W-5 -: COLOR_W];
  assign opdata = w_head[4*COORD_W-1:0];

  // Illegal opcodes are still accepted so the producer is never stalled by
  // them. Flush does not gate this: a discarded illegal opcode is always
  // reported and counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
      r_dropCnt <= 8'd0;
    end else begin
      r_illegal <= w_xfer && !w_legal;
      if (w_xfer && !w_legal && (r_dropCnt != 8'hFF)) begin
        r_dropCnt <= r_dropCnt + 8'd1;
      end
    end
  end

  assign illegal  = r_illegal;
  assign drop_cnt = r_dropCnt;

endmodule

// File: tb/tb_opcode_queue_decoder.sv
// tb_opcode_queue_decoder
// Directed bench for opcode_queue_decoder. One instance uses the default
// parameters (96-bit opcodes, depth 4); a second uses COORD_W=12, COLOR_W=8,
// DEPTH=8 to confirm the field slicing follows the parameters.
module tb_opcode_queue_decoder;

  logic        clk;
  logic        rst;

  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [95:0] opcode;
  logic        outValid;
  logic        outReady;
  logic [3:0]  shape;
  logic [15:0] color;
  logic [75:0] opdata;
  logic [2:0]  count;
  logic        illegal;
  logic [7:0]  dropCnt;

  logic        flushS;
  logic        inValidS;
  logic        inReadyS;
  logic [59:0] opcodeS;
  logic        outValidS;
  logic        outReadyS;
  logic [3:0]  shapeS;
  logic [7:0]  colorS;
  logic [47:0] opdataS;
  logic [3:0]  countS;
  logic        illegalS;
  logic [7:0]  dropCntS;

  int checkCount;
  int failCount;

  opcode_queue_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .opcode    (opcode),
    .out_valid (outValid),
    .out_ready (outReady),
    .shape     (shape),
    .color     (color),
    .opdata    (opdata),
    .count     (count),
    .illegal   (illegal),
    .drop_cnt  (dropCnt)
  );

  opcode_queue_decoder #(
    .COORD_W (12),
    .COLOR_W (8),
    .DEPTH   (8)
  ) dutSmall (
    .clk       (clk),
    .rst       (rst),
    .flush     (flushS),
    .in_valid  (inValidS),
    .in_ready  (inReadyS),
    .opcode    (opcodeS),
    .out_valid (outValidS),
    .out_ready (outReadyS),
    .shape     (shapeS),
    .color     (colorS),
    .opdata    (opdataS),
    .count     (countS),
    .illegal   (illegalS),
    .drop_cnt  (dropCntS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [95:0] op,
                               input logic rdy, input logic fl);
    inValid  = v;
    opcode   = op;
    outReady = rdy;
    flush    = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [95:0] makeOp(input logic [3:0] s, input int k);
    return {s, 16'(32'hC000 + k), 19'(k * 3 + 1), 19'(k * 5 + 2),
            19'(k * 7 + 3), 19'(32'h7FFFF - k)};
  endfunction

  function automatic logic [95:0] headWord();
    return {shape, color, opdata};
  endfunction

  initial begin
    logic [95:0] ops [4];
    logic [95:0] q [$];
    logic [95:0] nxt;
    logic [95:0] op0;
    logic [59:0] s0;
    logic [59:0] s1;

    checkCount = 0;
    failCount  = 0;
    op0 = {4'h0, 16'hFFFF, 19'h0, 19'h7FFFF, 19'h0, 19'h7FFFF};
    s0  = {4'h0, 8'hFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
    s1  = {4'h1, 8'hA5, 12'h123, 12'h456, 12'h789, 12'hABC};

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    flushS = 1'b0; inValidS = 1'b0; opcodeS = '0; outReadyS = 1'b0;
    step();
    checkOutput("rst_count",    128'(count),    128'(0));
    checkOutput("rst_outvalid", 128'(outValid), 128'(0));
    checkOutput("rst_inready",  128'(inReady),  128'(1));
    checkOutput("rst_illegal",  128'(illegal),  128'(0));
    checkOutput("rst_dropcnt",  128'(dropCnt),  128'(0));
    rst = 1'b0;
    step();

    // First push into an empty queue is visible one edge later
    applyStimulus(1'b1, op0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("first_outvalid", 128'(outValid), 128'(1));
    checkOutput("first_shape",    128'(shape),    128'(4'h0));
    checkOutput("first_color",    128'(color),    128'(16'hFFFF));
    checkOutput("first_opdata",   128'(opdata),   128'({19'h0, 19'h7FFFF, 19'h0, 19'h7FFFF}));
    checkOutput("first_count",    128'(count),    128'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    step();
    checkOutput("first_pop_count", 128'(count), 128'(0));

    // Fill to full, hold a fifth opcode, then drain in order
    for (int i = 0; i < 4; i++) begin
      ops[i] = makeOp(4'(i % 3), i);
      applyStimulus(1'b1, ops[i], 1'b0, 1'b0);
      step();
    end
    checkOutput("full_count",   128'(count),   128'(4));
    checkOutput("full_inready", 128'(inReady), 128'(0));
    applyStimulus(1'b1, makeOp(4'd2, 9), 1'b0, 1'b0);
    step();
    step();
    checkOutput("held_count", 128'(count),    128'(4));
    checkOutput("held_head",  128'(headWord()), 128'(ops[0]));
    // Pop while full with the fifth opcode still offered: no bypass
    applyStimulus(1'b1, makeOp(4'd2, 9), 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("nobypass_count", 128'(count), 128'(3));
    for (int i = 1; i < 4; i++) begin
      checkOutput("drain_head", 128'(headWord()), 128'(ops[i]));
      step();
    end
    checkOutput("drain_count",    128'(count),    128'(0));
    checkOutput("drain_inready",  128'(inReady),  128'(1));
    checkOutput("drain_outvalid", 128'(outValid), 128'(0));

    // Illegal opcodes: pulse, count, queue untouched, saturation
    applyStimulus(1'b1, makeOp(4'd1, 20), 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, {4'b0111, 92'h1234}, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("ill_pulse", 128'(illegal),    128'(1));
    checkOutput("ill_drop1", 128'(dropCnt),    128'(1));
    checkOutput("ill_count", 128'(count),      128'(1));
    checkOutput("ill_head",  128'(headWord()), 128'(makeOp(4'd1, 20)));
    step();
    checkOutput("ill_pulse_end", 128'(illegal), 128'(0));
    checkOutput("ill_drop_hold", 128'(dropCnt), 128'(1));
    for (int i = 0; i < 253; i++) begin
      applyStimulus(1'b1, {4'(3 + i % 13), 92'(i)}, 1'b0, 1'b0);
      step();
    end
    checkOutput("ill_drop254",   128'(dropCnt), 128'(254));
    checkOutput("ill_stream",    128'(illegal), 128'(1));
    step();
    checkOutput("ill_drop255",   128'(dropCnt), 128'(255));
    for (int i = 0; i < 46; i++) begin
      applyStimulus(1'b1, {4'hF, 92'(i)}, 1'b0, 1'b0);
      step();
    end
    checkOutput("ill_drop_sat",  128'(dropCnt), 128'(255));
    checkOutput("ill_count_end", 128'(count),   128'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("ill_idle",      128'(illegal), 128'(0));
    checkOutput("ill_pop_count", 128'(count),   128'(0));

    // Streaming push and pop with two entries resident
    q.delete();
    for (int i = 0; i < 2; i++) begin
      nxt = makeOp(4'(i), 100 + i);
      applyStimulus(1'b1, nxt, 1'b0, 1'b0);
      step();
      q.push_back(nxt);
    end
    for (int i = 0; i < 450; i++) begin
      nxt = {4'(i % 3), 16'($urandom), 19'($urandom), 19'($urandom),
             19'($urandom), 19'($urandom)};
      applyStimulus(1'b1, nxt, 1'b1, 1'b0);
      checkOutput("stream_head",  128'(headWord()), 128'(q[0]));
      checkOutput("stream_count", 128'(count),      128'(2));
      step();
      void'(q.pop_front());
      q.push_back(nxt);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("stream_tail", 128'(headWord()), 128'(q[0]));
      step();
      void'(q.pop_front());
    end
    checkOutput("stream_empty", 128'(count), 128'(0));

    // Flush with three queued and a legal opcode offered
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, makeOp(4'(i), 30 + i), 1'b0, 1'b0);
      step();
    end
    checkOutput("preflush_count", 128'(count), 128'(3));
    applyStimulus(1'b1, makeOp(4'd1, 40), 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("flush_count",    128'(count),    128'(0));
    checkOutput("flush_outvalid", 128'(outValid), 128'(0));
    checkOutput("flush_inready",  128'(inReady),  128'(1));
    step();
    checkOutput("flush_discard",  128'(count),    128'(0));
    applyStimulus(1'b1, {4'hF, 92'h5}, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("flush_ill_pulse", 128'(illegal), 128'(1));
    checkOutput("flush_ill_drop",  128'(dropCnt), 128'(255));
    checkOutput("flush_ill_count", 128'(count),   128'(0));
    applyStimulus(1'b1, makeOp(4'd0, 50), 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("postflush_head",  128'(headWord()), 128'(makeOp(4'd0, 50)));
    checkOutput("postflush_count", 128'(count),      128'(1));

    // Asynchronous reset mid-stream with two entries queued
    applyStimulus(1'b1, makeOp(4'd2, 51), 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("prerst_count", 128'(count), 128'(2));
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_outvalid", 128'(outValid), 128'(0));
    checkOutput("arst_count",    128'(count),    128'(0));
    checkOutput("arst_inready",  128'(inReady),  128'(1));
    checkOutput("arst_dropcnt",  128'(dropCnt),  128'(0));
    #2 rst = 1'b0;
    step();
    applyStimulus(1'b1, makeOp(4'd1, 60), 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("postrst_count", 128'(count),      128'(1));
    checkOutput("postrst_head",  128'(headWord()), 128'(makeOp(4'd1, 60)));

    // Second parameter set: bit-exact fields and depth 8
    inValidS = 1'b1; opcodeS = s0;
    step();
    opcodeS = s1;
    checkOutput("small_outvalid", 128'(outValidS), 128'(1));
    checkOutput("small_shape",    128'(shapeS),    128'(4'h0));
    checkOutput("small_color",    128'(colorS),    128'(8'hFF));
    checkOutput("small_opdata",   128'(opdataS),   128'({12'h000, 12'hFFF, 12'h000, 12'hFFF}));
    checkOutput("small_count1",   128'(countS),    128'(1));
    step();
    inValidS = 1'b0; outReadyS = 1'b1;
    checkOutput("small_count2", 128'(countS), 128'(2));
    step();
    outReadyS = 1'b0;
    checkOutput("small_shape2",  128'(shapeS),  128'(4'h1));
    checkOutput("small_color2",  128'(colorS),  128'(8'hA5));
    checkOutput("small_opdata2", 128'(opdataS), 128'({12'h123, 12'h456, 12'h789, 12'hABC}));
    inValidS = 1'b1; opcodeS = s0;
    for (int i = 0; i < 7; i++) begin
      step();
    end
    inValidS = 1'b0;
    checkOutput("small_full_count",   128'(countS),   128'(8));
    checkOutput("small_full_inready", 128'(inReadyS), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/opcode_queue_decoder.md
OPCODE_QUEUE_DECODER -- requirements
Module: opcode_queue_decoder

Interface
REQ-001 SHALL have parameter COORD_W, default 19, width of each of four coordinate fields.
REQ-002 SHALL have parameter COLOR_W, default 16, width of the colour field.
REQ-003 SHALL have parameter DEPTH, default 4, queue depth; power of two, at least 2.
REQ-004 SHALL derive localparam OP_W = 4 + COLOR_W + 4*COORD_W (96 at defaults) and CNT_W = $clog2(DEPTH+1).
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  synchronous queue clear.
REQ-008 in_valid  input  1  opcode present.
REQ-009 in_ready  output  1  block can accept opcode.
REQ-010 opcode  input  OP_W  raw opcode: shape [OP_W-1:OP_W-4], colour next COLOR_W bits, opdata low 4*COORD_W bits.
REQ-011 out_valid  output  1  decoded opcode at queue head.
REQ-012 out_ready  input  1  consumer takes head.
REQ-013 shape  output  4  head shape field.
REQ-014 color  output  COLOR_W  head colour field.
REQ-015 opdata  output  4*COORD_W  head coordinate fields, bit order unchanged from opcode.
REQ-016 count  output  CNT_W  queue occupancy.
REQ-017 illegal  output  1  one-cycle pulse: an illegal opcode was discarded.
REQ-018 drop_cnt  output  8  saturating count of discarded opcodes.

Function
REQ-019 Legal shapes SHALL be LINE=4'b0000, TRIANGLE=4'b0001 and CIRCLE=4'b0010; every other value is illegal.
REQ-020 An input transfer SHALL occur when in_valid && in_ready at a rising edge.
REQ-021 in_ready SHALL be !full, combinational from registered occupancy; no bypass when full, even if a pop occurs the same cycle.
REQ-022 A legal opcode SHALL be written to the tail on transfer.
REQ-023 An illegal opcode SHALL be accepted, not stored, and SHALL cause illegal=1 for exactly the next cycle.
REQ-024 An illegal opcode SHALL increment drop_cnt, saturating at 255.
REQ-025 Pop SHALL occur when out_valid && out_ready; the head advances by one.
REQ-026 out_valid SHALL equal (count != 0).
REQ-027 shape, color and opdata SHALL be combinational slices of the head entry and SHALL remain stable while out_valid && !out_ready.
REQ-028 Latency: opcode accepted at edge N SHALL be visible at the outputs from edge N onward when the queue was empty (one-cycle latency, no combinational in-to-out path).
REQ-029 Simultaneous push and pop when not full and not empty SHALL leave count unchanged.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 Full SHALL be count==DEPTH; empty SHALL be count==0.
REQ-032 flush SHALL set count and both pointers to 0 next edge and overrides push/pop that cycle.
REQ-033 flush SHALL NOT alter drop_cnt; an illegal opcode presented during flush still pulses illegal and counts.
REQ-034 Data SHALL be bit-exact: shape, color and opdata equal the corresponding opcode slices for every parameter set.

Reset
REQ-035 rst SHALL asynchronously clear pointers, count, illegal and drop_cnt to 0; consequently out_valid=0 and in_ready=1.
REQ-036 Queue storage SHALL NOT require reset; outputs SHALL be don't-care while out_valid=0.
REQ-037 Reset mid-operation SHALL discard all queued entries; the first transfer after deassertion behaves as into an empty queue.

Structure
REQ-038 A shared package gpu_pkg SHALL hold the shape_t enum (LINE, TRIANGLE, CIRCLE) and default COORD_W and COLOR_W constants, shared with the existing opcode decoder.
REQ-039 Storage and pointers SHALL be one sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, flush, full, empty, count); decode and illegal filtering live in the top.

Verification
REQ-040 Reset, then push LINE opcode {0000, FFFF, 19'h0, 19'h7FFFF, 19'h0, 19'h7FFFF} with out_ready=0 -> next cycle out_valid=1, shape=0, color=FFFF, opdata matches, count=1.
REQ-041 Push 4 legal opcodes with out_ready=0 -> count=4, in_ready=0; 5th held opcode not accepted; out_ready=1 -> 4 entries pop in FIFO order, then in_ready=1.
REQ-042 Push shape 4'b0111 -> illegal high exactly one cycle, drop_cnt=1, count unchanged; 300 illegal pushes -> drop_cnt=255.
REQ-043 Continuous push and pop with in_valid=out_ready=1 for 450 random legal opcodes (150 each shape) -> count constant, output sequence equals input sequence, pointers wrap.
REQ-044 flush asserted with count=3 and in_valid=1 legal -> next cycle count=0, out_valid=0, that opcode discarded.
REQ-045 rst asserted asynchronously mid-stream with count=2 -> out_valid=0 immediately; rerun REQ-040 with COORD_W=12, COLOR_W=8, DEPTH=8 -> bit-exact fields.
